multi_channel_divider: RTL and testbench
========================================

# multi_channel_divider

Parametrised, multi-channel successor to the single-output frequency divider. It generates CHANNELS independent divided clocks from one system clock, each with its own runtime factor, enable and one-cycle edge ticks. Factor changes take effect without glitches at period boundaries, and all channels can be phase-aligned by a common restart. It feeds the I2C/SPI controllers and any block that needs slow strobes or toggling clocks derived from `clk`.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16).
- DIV_BITS, 16, width of each channel's factor and counter.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  CHANNELS  per-channel run enable.
- factor  in  CHANNELS*DIV_BITS  packed factors; channel i is at [i*DIV_BITS +: DIV_BITS].
- load  in  CHANNELS  per-channel request to adopt the current `factor` slice while running.
- sync_restart  in  1  restarts all enabled channels in phase.
- dclk  out  CHANNELS  registered divided clocks.
- tick_rise  out  CHANNELS  one-cycle pulse, high in the cycle dclk[i] first reads 1.
- tick_fall  out  CHANNELS  one-cycle pulse, high in the cycle dclk[i] first reads 0.
- pending  out  CHANNELS  high while a loaded factor waits for its period boundary.

## Operation
- Per-channel state: counter cnt (DIV_BITS), active factor act, shadow factor shd, pending flag, dclk register.
- Run (en=1): if cnt == act, toggle dclk and set cnt to 0. Otherwise cnt increments.
- Each half-period is act+1 cycles; the full period is 2*(act+1).
- act=0 gives clk/2. act=2^DIV_BITS−1 gives the slowest output, with no counter overflow.
- Disabled (en=0): cnt=0, dclk=0, pending=0, and act tracks the factor slice every cycle. No ticks are generated, except tick_fall when a high dclk is forced low.
- Load (load[i]=1 while en[i]=1): shd takes the factor slice and pending is set.
  - A second load while pending overwrites shd. Only the last value applies.
- Apply: on the toggle cycle where dclk goes 1→0 with pending=1, act takes shd and pending clears in the same edge. The new factor governs the next low half.
- A load on the same edge as an apply: the apply uses the old shd, then the new value is captured and pending stays 1.
- sync_restart=1: every enabled channel sets cnt=0 and dclk=0. A pending shd is applied and pending clears.
  - A channel whose dclk was 1 emits tick_fall.
  - Disabled channels are unaffected.
- Priority, highest first: rst_n, sync_restart, en=0, load/toggle.
- Channels share no state other than sync_restart.

## Timing
- Reset values: dclk=0, tick_rise=0, tick_fall=0, pending=0, cnt=0, act=0, shd=0. All are asynchronous on rst_n low.
- Leaving reset, and every en 0→1, follows the same rule:
  - en[i] is first sampled high at edge E0 and the channel is otherwise in the disabled state (cnt=0, dclk=0).
  - dclk[i] reads 1 after edge E0+act. tick_rise[i] is high for exactly that cycle.
- The load→pending latency is 1 edge.
- Apply latency is bounded by one full period plus one cycle.
- Ticks come from the same registers as dclk. There is zero-cycle skew between dclk and its tick, and no combinational path from inputs to outputs.
- Removing en mid-period forces dclk to 0 on the next edge.

## Configuration
- MULTI_DIVIDER_TICK_EN defined: tick_rise/tick_fall registers are built as described.
- MULTI_DIVIDER_TICK_EN undefined: the tick ports remain, tied to constant 0, and no tick logic is synthesised.
- dclk, pending and all other behaviour are identical with and without the macro.

## Test plan
- Reset with en=4'b0001, factor[0]=3: dclk[0] rises 4 cycles after release, period 8 cycles. tick_rise/tick_fall are single-cycle and aligned to dclk edges.
- factor[0]=0, en=1: dclk[0] toggles every cycle (clk/2). tick_rise and tick_fall alternate each cycle.
- Running at factor=5, load a factor of 1 mid-high-half: pending=1 until the next 1→0 toggle, then the low half is 2 cycles. There is no short pulse before the boundary.
- Channels 0..3 at factors 1,2,3,4, then assert sync_restart for 1 cycle: all dclk=0 next cycle. A tick_fall fires only on channels that were high, and all rising edges align to the new factors.
- Drop en[2] while dclk[2]=1 and change factor[2] to 7: dclk[2]=0 next cycle with tick_fall. On re-enable, the first rise comes after 8 cycles.
- Assert rst_n low asynchronously mid-period with pending=1: all outputs are 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/multi_channel_divider_if.sv
// rtl/multi_channel_divider_if.sv - control/status bundle for multi_channel_divider
interface multi_channel_divider_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_BITS = 16
);
    logic [CHANNELS-1:0]          en;
    logic [CHANNELS*DIV_BITS-1:0] factor;
    logic [CHANNELS-1:0]          load;
    logic                         sync_restart;
    logic [CHANNELS-1:0]          dclk;
    logic [CHANNELS-1:0]          tick_rise;
    logic [CHANNELS-1:0]          tick_fall;
    logic [CHANNELS-1:0]          pending;

    modport master (
        output en, factor, load, sync_restart,
        input  dclk, tick_rise, tick_fall, pending
    );

    modport slave (
        input  en, factor, load, sync_restart,
        output dclk, tick_rise, tick_fall, pending
    );
endinterface

// File: rtl/multi_channel_divider.sv
// rtl/multi_channel_divider.sv - CHANNELS independent clock dividers, tick logic under MULTI_DIVIDER_TICK_EN
module multi_channel_divider #(
    parameter int CHANNELS = 4,
    parameter int DIV_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_channel_divider_if.slave bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_BITS-1:0] cnt;
        logic [DIV_BITS-1:0] act;
        logic [DIV_BITS-1:0] shd;
        logic [DIV_BITS-1:0] fac;
        logic [DIV_BITS-1:0] act_eff;
        logic                run_q;
        logic                pend_q;
        logic                dclk_q;
        logic                dclk_nxt;
        logic                hit;

        assign fac = bus.factor[i*DIV_BITS +: DIV_BITS];
        // On the first enabled edge the factor present on the bus governs,
        // so leaving reset and re-enabling share one start-up rule.
        assign act_eff = run_q ? act : fac;
        assign hit     = (cnt == act_eff);

        // Next dclk value: forced low by restart or disable, toggled at the half-period end
        always_comb begin
            dclk_nxt = dclk_q;
            if (!bus.en[i] || bus.sync_restart) begin
                dclk_nxt = 1'b0;
            end else if (hit) begin
                dclk_nxt = ~dclk_q;
            end
        end

        // Divider counter, factor shadowing and glitch-free apply at the falling boundary
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                act    <= '0;
                shd    <= '0;
                pend_q <= 1'b0;
                run_q  <= 1'b0;
                dclk_q <= 1'b0;
            end else begin
                run_q  <= bus.en[i];
                dclk_q <= dclk_nxt;
                if (!bus.en[i]) begin
                    cnt    <= '0;
                    act    <= fac;
                    pend_q <= 1'b0;
                end else if (bus.sync_restart) begin
                    cnt    <= '0;
                    act    <= pend_q ? shd : act_eff;
                    pend_q <= 1'b0;
                end else begin
                    act <= act_eff;
                    if (hit) begin
                        cnt <= '0;
                        if (dclk_q && pend_q) begin
                            act    <= shd;
                            pend_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // A load on the apply edge is captured after the old shadow was used
                    if (bus.load[i]) begin
                        shd    <= fac;
                        pend_q <= 1'b1;
                    end
                end
            end
        end

        assign bus.dclk[i]    = dclk_q;
        assign bus.pending[i] = pend_q;

`ifdef MULTI_DIVIDER_TICK_EN
        logic rise_q;
        logic fall_q;

        // Edge ticks registered alongside dclk so they share its timing exactly
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= dclk_nxt & ~dclk_q;
                fall_q <= ~dclk_nxt & dclk_q;
            end
        end

        assign bus.tick_rise[i] = rise_q;
        assign bus.tick_fall[i] = fall_q;
`else
        assign bus.tick_rise[i] = 1'b0;
        assign bus.tick_fall[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_channel_divider.sv
// tb/tb_multi_channel_divider.sv - directed self-checking bench for multi_channel_divider
module tb_multi_channel_divider;
    localparam int CHANNELS = 4;
    localparam int DIV_BITS = 16;
`ifdef MULTI_DIVIDER_TICK_EN
    localparam bit TICKS = 1'b1;
`else
    localparam bit TICKS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multi_channel_divider_if #(.CHANNELS(CHANNELS), .DIV_BITS(DIV_BITS)) bus ();

    multi_channel_divider #(.CHANNELS(CHANNELS), .DIV_BITS(DIV_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_factor(input int ch, input logic [DIV_BITS-1:0] val);
        bus.factor[ch*DIV_BITS +: DIV_BITS] = val;
    endtask

    // ed[k]/ep[k]: expected dclk/pending after edge k; ed[k0-1] is the level before
    task automatic run_seq(input int ch, input int k0, input int k1,
                           input logic [31:0] ed, input logic [31:0] ep, input string tag);
        for (int k = k0; k <= k1; k++) begin
            step();
            check($sformatf("%s_dclk_k%0d", tag, k), bus.dclk[ch], ed[k]);
            check($sformatf("%s_rise_k%0d", tag, k), bus.tick_rise[ch], TICKS & ed[k] & ~ed[k-1]);
            check($sformatf("%s_fall_k%0d", tag, k), bus.tick_fall[ch], TICKS & ~ed[k] & ed[k-1]);
            check($sformatf("%s_pend_k%0d", tag, k), bus.pending[ch], ep[k]);
        end
    endtask

    function automatic logic [3:0] phase_vec(input int k);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = ((k / (c + 2)) % 2) == 1;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.en = 4'b0001;
        bus.factor = '0;
        bus.load = '0;
        bus.sync_restart = 1'b0;
        set_factor(0, 16'd3);
        #2;
        check("rst_dclk", bus.dclk, 0);
        check("rst_pend", bus.pending, 0);
        check("rst_rise", bus.tick_rise, 0);
        check("rst_fall", bus.tick_fall, 0);
        step();
        step();
        rst_n = 1'b1;

        // factor 3: rise after the 4th edge, period 8
        run_seq(0, 1, 16, 32'b0_1111_0000_1111_0000, 32'd0, "f3");
        check("f3_others_idle", bus.dclk[3:1], 0);

        // factor 0: clk/2
        bus.en[0] = 1'b0;
        set_factor(0, 16'd0);
        step();
        check("f0_dis_dclk", bus.dclk[0], 0);
        bus.en[0] = 1'b1;
        run_seq(0, 1, 8, 32'b0_1010_1010, 32'd0, "f0");

        // factor 5, load 1 in the high half, applied at the next fall
        bus.en[0] = 1'b0;
        set_factor(0, 16'd5);
        step();
        check("ld_dis_dclk", bus.dclk[0], 0);
        bus.en[0] = 1'b1;
        run_seq(0, 1, 8, 32'b0_1100_1111_1100_0000, 32'b0_0000_1110_0000_0000, "ld");
        bus.load[0] = 1'b1;
        set_factor(0, 16'd1);
        run_seq(0, 9, 9, 32'b0_1100_1111_1100_0000, 32'b0_0000_1110_0000_0000, "ld");
        bus.load[0] = 1'b0;
        run_seq(0, 10, 16, 32'b0_1100_1111_1100_0000, 32'b0_0000_1110_0000_0000, "ld");

        // four channels at factors 1..4, then a common restart
        bus.en = 4'b0000;
        for (int c = 0; c < 4; c++) set_factor(c, DIV_BITS'(c + 1));
        step();
        check("sr_dis_dclk", bus.dclk, 0);
        bus.en = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("sr_pre_k%0d", k), bus.dclk, phase_vec(k));
        end
        bus.sync_restart = 1'b1;
        step();
        bus.sync_restart = 1'b0;
        check("sr_dclk", bus.dclk, 0);
        check("sr_fall", bus.tick_fall, TICKS ? 4'b1101 : 4'b0000);
        check("sr_rise", bus.tick_rise, 0);
        for (int j = 1; j <= 5; j++) begin
            step();
            check($sformatf("sr_post_j%0d", j), bus.dclk, phase_vec(j));
        end

        // drop en[2] while high, new factor 7, re-enable
        bus.en[2] = 1'b0;
        set_factor(2, 16'd7);
        step();
        check("dis_dclk2", bus.dclk[2], 0);
        check("dis_fall2", bus.tick_fall[2], TICKS);
        bus.en[2] = 1'b1;
        run_seq(2, 1, 10, 32'b111_0000_0000, 32'd0, "re");

        // async reset mid-period with a load pending
        bus.load[2] = 1'b1;
        set_factor(2, 16'd3);
        step();
        bus.load[2] = 1'b0;
        check("ar_pend_set", bus.pending[2], 1);
        check("ar_dclk_high", bus.dclk[2], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_dclk", bus.dclk, 0);
        check("ar_pend", bus.pending, 0);
        check("ar_rise", bus.tick_rise, 0);
        check("ar_fall", bus.tick_fall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
